// File: rtl/insn_pkg.sv
// insn_pkg: shared encoder types and constants.
//   fmt_e          - instruction format codes carried on the fmt port
//   OPC_*          - RV32I major opcodes
//   insn_fields_t  - register/function/opcode payload handed to imm_pack
//   enc_state_e    - output register occupancy
//   fits_signed()  - true when a 32-bit value is representable in n signed bits
package insn_pkg;

    localparam int unsigned FMT_W  = 3;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned INSN_W = 32;

    typedef enum logic [FMT_W-1:0] {
        FMT_U = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
    } insn_fields_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } enc_state_e;

    // Value fits in n signed bits when everything from bit n-1 upward is a sign copy.
    function automatic logic fits_signed(input logic [INSN_W-1:0] v, input int unsigned n);
        logic signed [INSN_W-1:0] hi;
        hi = $signed(v) >>> (n - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational RV32I field packing and immediate range check.
//   fmt       - format code (6/7 illegal -> insn_next=0, err_next=1)
//   fields    - opcode, rd, rs1, rs2, funct3, funct7
//   imm       - signed immediate (byte offset for B/J, full value for U)
//   insn_next - packed instruction word (truncated encoding even on error)
//   err_next  - immediate not representable or illegal format
module imm_pack
    import insn_pkg::*;
(
    input  logic [FMT_W-1:0]  fmt,
    input  insn_fields_t      fields,
    input  logic [INSN_W-1:0] imm,
    output logic [INSN_W-1:0] insn_next,
    output logic              err_next
);

    // Field placement per format.
    always_comb begin
        insn_next = '0;
        err_next  = 1'b0;
        case (fmt)
            FMT_U: begin
                insn_next = {imm[31:12], fields.rd, fields.opcode};
                err_next  = (imm[11:0] != 12'd0);
            end
            FMT_I: begin
                insn_next = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
                err_next  = !fits_signed(imm, 12);
            end
            FMT_S: begin
                insn_next = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                             imm[4:0], fields.opcode};
                err_next  = !fits_signed(imm, 12);
            end
            FMT_B: begin
                insn_next = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                             imm[4:1], imm[11], fields.opcode};
                // 13-bit signed range with bit 0 zero caps the top at 4094.
                err_next  = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J: begin
                insn_next = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
                err_next  = !fits_signed(imm, 21) || imm[0];
            end
            FMT_R: begin
                insn_next = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
                err_next  = 1'b0;
            end
            default: begin
                insn_next = '0;
                err_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/insn_enc.sv
// insn_enc: RV32I instruction encoder with a one-entry valid/ready output register.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - request handshake (in_ready is combinational)
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm - request fields
//   out_valid, out_ready - result handshake
//   insn, err           - registered encoding and error flag
//   count               - wrapping count of output handshakes
module insn_enc
    import insn_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FMT_W-1:0]  fmt,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [F3_W-1:0]   funct3,
    input  logic [F7_W-1:0]   funct7,
    input  logic [INSN_W-1:0] imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] insn,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    enc_state_e        state_q;
    enc_state_e        state_d;
    logic              load_c;
    logic              take_c;
    insn_fields_t      fields;
    logic [INSN_W-1:0] insn_next;
    logic              err_next;

    assign fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                      funct3: funct3, funct7: funct7};

    imm_pack u_imm_pack (
        .fmt       (fmt),
        .fields    (fields),
        .imm       (imm),
        .insn_next (insn_next),
        .err_next  (err_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on request, drain when consumer takes without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_valid)               state_d = ST_FULL;
            ST_FULL:  if (out_ready && !in_valid) state_d = ST_EMPTY;
            default:                              state_d = ST_EMPTY;
        endcase
    end

    // Handshake decode; a full register can refill in the cycle it is drained.
    always_comb begin
        in_ready  = (state_q == ST_EMPTY) || out_ready;
        out_valid = (state_q == ST_FULL);
        load_c    = in_valid && in_ready;
        take_c    = out_valid && out_ready;
    end

    // Output register and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            insn  <= '0;
            err   <= 1'b0;
            count <= '0;
        end else begin
            if (load_c) begin
                insn <= insn_next;
                err  <= err_next;
            end
            if (take_c) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
